instr_fetch_unit: RTL and testbench

Instruction fetch unit for the single-cycle RISC-V core: owns the architectural PC register, fetches the word at `pc` from instruction memory over a req/ack handshake, and presents the instruction to the decode/execute datapath. It is the consumer end of the next-PC path. It accepts `nextpc` from the PC selector and drives `waitt` back to it, so the selector only advances once a fetch has completed. It also detects misaligned and bus-error fetches and counts retired instructions.

---
 rtl/instr_fetch_unit_if.sv | 24 ++
 rtl/instr_fetch_unit.sv | 85 ++++++++
 tb/tb_instr_fetch_unit.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus: PC handshake with the next-PC selector plus the instruction-memory req/ack port.
interface instr_fetch_unit_if;
  logic [31:0] pc;
  logic [31:0] nextpc;
  logic [31:0] instr;
  logic        waitt;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        imem_err;
  logic        fetch_fault;
  logic [31:0] instret;

  modport master (
    output pc, instr, waitt, imem_req, imem_addr, fetch_fault, instret,
    input  nextpc, imem_ack, imem_rdata, imem_err
  );

  modport slave (
    input  pc, instr, waitt, imem_req, imem_addr, fetch_fault, instret,
    output nextpc, imem_ack, imem_rdata, imem_err
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches over req/ack, counts retired instructions.
// state | meaning
// IDLE  | one quiet cycle after reset
// REQ   | request outstanding at pc, waiting for ack
// DONE  | instr valid, selector presents nextpc
// FAULT | misaligned pc or bus error; held until reset
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h80000000,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input logic               clk,
  input logic               reset,
  instr_fetch_unit_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DONE  = 2'd2,
    FAULT = 2'd3
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic        fault_q;
  logic [31:0] instret_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      instr_q   <= NOP_INSTR;
      fault_q   <= 1'b0;
      instret_q <= 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pc_q[1:0] != 2'b00) begin
            fault_q <= 1'b1;
            instr_q <= NOP_INSTR;
            state_q <= FAULT;
          end else begin
            state_q <= REQ;
          end
        end
        REQ: begin
          if (bus.imem_ack) begin
            if (bus.imem_err) begin
              fault_q <= 1'b1;
              instr_q <= NOP_INSTR;
              state_q <= FAULT;
            end else begin
              instr_q <= bus.imem_rdata;
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          instret_q <= instret_q + 32'd1;
          pc_q      <= bus.nextpc;
          // misaligned target is kept in pc so it can be inspected after the fault
          if (bus.nextpc[1:0] != 2'b00) begin
            fault_q <= 1'b1;
            instr_q <= NOP_INSTR;
            state_q <= FAULT;
          end else begin
            state_q <= REQ;
          end
        end
        default: state_q <= FAULT;
      endcase
    end
  end

  // handshake outputs decode the state register only, so reset drops imem_req at once
  assign bus.imem_req    = (state_q == REQ);
  assign bus.waitt       = (state_q == DONE);
  assign bus.imem_addr   = pc_q;
  assign bus.pc          = pc_q;
  assign bus.instr       = instr_q;
  assign bus.fetch_fault = fault_q;
  assign bus.instret     = instret_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a memory model answers fetches and a scoreboard checks
// each delivered instruction/PC pair when waitt is raised.
module tb_instr_fetch_unit;
  localparam logic [31:0] RST_PC = 32'h80000000;
  localparam logic [31:0] NOP    = 32'h00000013;
  localparam logic [31:0] XOR_K  = 32'hA5A5A5A5;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  instr_fetch_unit_if bus();

  instr_fetch_unit #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] model_pc;
  logic [31:0] model_instret;
  exp_t        sb_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Asserts reset asynchronously mid-cycle, checks reset values, then walks IDLE into the first REQ.
  task automatic do_reset(input bit stale_ack);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("rst_req", {31'd0, bus.imem_req}, 32'd0);
    chk("rst_waitt", {31'd0, bus.waitt}, 32'd0);
    chk("rst_pc", bus.pc, RST_PC);
    chk("rst_instr", bus.instr, NOP);
    chk("rst_instret", bus.instret, 32'd0);
    chk("rst_fault", {31'd0, bus.fetch_fault}, 32'd0);
    sb_q.delete();
    model_pc = RST_PC;
    model_instret = 32'd0;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("idle_req", {31'd0, bus.imem_req}, 32'd0);
    chk("idle_waitt", {31'd0, bus.waitt}, 32'd0);
    if (stale_ack) begin
      bus.imem_ack   = 1'b1;
      bus.imem_rdata = 32'hDEADBEEF;
    end
    @(negedge clk);
    bus.imem_ack = 1'b0;
    chk("first_req", {31'd0, bus.imem_req}, 32'd1);
    chk("first_addr", bus.imem_addr, RST_PC);
    chk("first_instr", bus.instr, NOP);
    chk("first_waitt", {31'd0, bus.waitt}, 32'd0);
    chk("first_instret", bus.instret, 32'd0);
  endtask

  // Called at a negedge while in REQ; n stall cycles, then ack (with err=e), then DONE with nextpc=nxt.
  task automatic do_fetch(input int n, input bit e, input logic [31:0] nxt);
    exp_t ex;
    chk("req", {31'd0, bus.imem_req}, 32'd1);
    chk("addr", bus.imem_addr, model_pc);
    for (int i = 0; i < n; i++) begin
      bus.imem_ack   = 1'b0;
      bus.imem_err   = (i == 0);
      bus.imem_rdata = $urandom;
      @(negedge clk);
      chk("stall_req", {31'd0, bus.imem_req}, 32'd1);
      chk("stall_waitt", {31'd0, bus.waitt}, 32'd0);
      chk("stall_addr", bus.imem_addr, model_pc);
    end
    bus.imem_ack   = 1'b1;
    bus.imem_err   = e;
    bus.imem_rdata = model_pc ^ XOR_K;
    if (!e) sb_q.push_back('{pc: model_pc, instr: model_pc ^ XOR_K});
    @(negedge clk);
    bus.imem_ack   = 1'b0;
    bus.imem_err   = 1'b0;
    bus.imem_rdata = $urandom;
    if (e) begin
      chk("berr_fault", {31'd0, bus.fetch_fault}, 32'd1);
      chk("berr_instr", bus.instr, NOP);
      chk("berr_req", {31'd0, bus.imem_req}, 32'd0);
      chk("berr_waitt", {31'd0, bus.waitt}, 32'd0);
      chk("berr_instret", bus.instret, model_instret);
      return;
    end
    chk("done_waitt", {31'd0, bus.waitt}, 32'd1);
    chk("done_req", {31'd0, bus.imem_req}, 32'd0);
    chk("done_fault", {31'd0, bus.fetch_fault}, 32'd0);
    ex = sb_q.pop_front();
    chk("done_instr", bus.instr, ex.instr);
    chk("done_pc", bus.pc, ex.pc);
    bus.nextpc = nxt;
    model_instret = model_instret + 32'd1;
    @(negedge clk);
    bus.nextpc = $urandom;
    model_pc = nxt;
    chk("next_instret", bus.instret, model_instret);
    chk("next_pc", bus.pc, model_pc);
    chk("next_waitt", {31'd0, bus.waitt}, 32'd0);
    if (nxt[1:0] != 2'b00) begin
      chk("mis_fault", {31'd0, bus.fetch_fault}, 32'd1);
      chk("mis_req", {31'd0, bus.imem_req}, 32'd0);
      chk("mis_instr", bus.instr, NOP);
    end else begin
      chk("next_req", {31'd0, bus.imem_req}, 32'd1);
      chk("held_instr", bus.instr, ex.instr);
    end
  endtask

  task automatic hold_fault(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      bus.imem_ack   = 1'($urandom_range(0, 1));
      bus.imem_err   = 1'($urandom_range(0, 1));
      bus.imem_rdata = $urandom;
      bus.nextpc     = $urandom;
      @(negedge clk);
      chk("flt_fault", {31'd0, bus.fetch_fault}, 32'd1);
      chk("flt_pc", bus.pc, model_pc);
      chk("flt_req", {31'd0, bus.imem_req}, 32'd0);
      chk("flt_waitt", {31'd0, bus.waitt}, 32'd0);
      chk("flt_instr", bus.instr, NOP);
      chk("flt_instret", bus.instret, model_instret);
    end
    bus.imem_ack = 1'b0;
    bus.imem_err = 1'b0;
  endtask

  initial begin
    bus.nextpc     = 32'd0;
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 32'd0;
    bus.imem_err   = 1'b0;

    // zero-wait run, wait-state jump, then misaligned target
    do_reset(1'b0);
    do_fetch(0, 1'b0, 32'h80000004);
    do_fetch(0, 1'b0, 32'h80000008);
    do_fetch(0, 1'b0, 32'h8000000C);
    chk("instret_three", bus.instret, 32'd3);
    do_fetch(3, 1'b0, 32'h80000100);
    do_fetch(2, 1'b0, 32'h80000002);
    hold_fault(25);

    // bus error on the fetch at 80000004
    do_reset(1'b0);
    do_fetch(0, 1'b0, 32'h80000004);
    do_fetch(1, 1'b1, 32'h0);
    hold_fault(5);

    // reset during a stalled REQ, stale ack injected in the IDLE cycle
    do_reset(1'b0);
    bus.imem_ack = 1'b0;
    @(negedge clk);
    chk("stall_before_rst", {31'd0, bus.imem_req}, 32'd1);
    do_reset(1'b1);
    do_fetch(0, 1'b0, 32'h80000004);
    chk("restart_instret", bus.instret, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
